// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises the rx pin, times bits from a runtime count k,
// and deserialises 7/8 data bits plus optional parity and one stop bit.
module uart_rx_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [18:0] k,
  input  logic        eight,
  input  logic        p_en,
  input  logic        ohel,
  input  logic        read,
  output logic        rx_rdy,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overflow,
  output logic [7:0]  data_to_TB,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [18:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  data_q, data_d;

  logic [18:0] target;
  logic        btu;
  logic        done;
  logic [3:0]  nbits;
  logic [9:0]  frame_bits;
  logic [7:0]  rx_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '1;
      rx_rdy_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      data_q       <= '0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_rdy_q     <= rx_rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      data_q       <= data_d;
    end
  end

  // Bits taken after the start bit: data (7/8) + optional parity + stop.
  assign nbits  = 4'd8 + {3'b000, eight} + {3'b000, p_en};
  // START waits half a bit so every later sample lands mid-bit.
  assign target = (state_q == S_START) ? {1'b0, k[18:1]} : k;
  assign btu    = (state_q != S_IDLE) && (cnt_q == target);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) begin
          state_d   = S_START;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        cnt_d = btu ? 19'd0 : cnt_q + 19'd1;
        if (btu) state_d = rx_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        cnt_d = btu ? 19'd0 : cnt_q + 19'd1;
        if (btu) begin
          shift_d   = {rx_sync_q, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_d == nbits) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The stop bit is always the newest bit (shift_d[9]); parity, if present, sits just below it.
  assign frame_bits = shift_d >> (4'd10 - nbits);
  assign rx_data    = {eight & frame_bits[7], frame_bits[6:0]};

  // Host handshake: rx_rdy is the valid flag and read is the level-sensitive
  // acknowledge; a frame completing in the same cycle as read wins.
  always_comb begin
    rx_rdy_d     = rx_rdy_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overflow_d   = overflow_q;
    data_d       = data_q;
    if (done) begin
      data_d       = rx_data;
      parity_err_d = p_en & (shift_d[8] != (^rx_data ^ ohel));
      frame_err_d  = ~shift_d[9];
      overflow_d   = rx_rdy_q;
      rx_rdy_d     = 1'b1;
    end else if (read) begin
      rx_rdy_d     = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  assign rx_rdy     = rx_rdy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign data_to_TB = data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: table-driven frames, random frames and
// hand-written corner sequences, all checked through an expected-result queue.
module tb_uart_rx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [18:0] k;
  logic        eight, p_en, ohel, read;
  logic        rx_rdy, parity_err, frame_err, overflow;
  logic [7:0]  data_to_TB;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // {data[7:0], parity_err, frame_err, overflow}
  logic [10:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic       eight, p_en, ohel, flip, stop, do_read;
    logic [7:0] exp_data;
    logic       exp_perr, exp_ferr, exp_ovf;
  } vec_t;

  vec_t vecs[8];

  uart_rx_engine dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .k          (k),
    .eight      (eight),
    .p_en       (p_en),
    .ohel       (ohel),
    .read       (read),
    .rx_rdy     (rx_rdy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .data_to_TB (data_to_TB),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e, input logic pe,
                            input logic oh, input logic flip, input logic stop);
    int   bp;
    logic par;
    bp    = int'(k) + 1;
    eight = e;
    p_en  = pe;
    ohel  = oh;
    par   = (^(d & (e ? 8'hFF : 8'h7F))) ^ oh ^ flip;
    drive_bit(1'b0, bp);
    for (int i = 0; i < 7 + int'(e); i++) drive_bit(d[i], bp);
    if (pe) drive_bit(par, bp);
    if (stop) drive_bit(1'b1, bp);
    else begin
      drive_bit(1'b0, bp / 2 + 8);
      drive_bit(1'b1, bp - bp / 2 - 8);
    end
    drive_bit(1'b1, 2 * bp);
  endtask

  task automatic pulse_read();
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check("read_clr_rx_rdy", rx_rdy, 0);
    check("read_clr_perr", parity_err, 0);
    check("read_clr_ferr", frame_err, 0);
    check("read_clr_ovf", overflow, 0);
  endtask

  // Scoreboard pop
  task automatic pop_check(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s scoreboard: queue empty, got data %0h", tag, data_to_TB);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_rx_rdy"}, rx_rdy, 1);
    check({tag, "_data"}, data_to_TB, e[10:3]);
    check({tag, "_perr"}, parity_err, e[2]);
    check({tag, "_ferr"}, frame_err, e[1]);
    check({tag, "_ovf"}, overflow, e[0]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_rdy"}, rx_rdy, 0);
    check({tag, "_perr"}, parity_err, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_data"}, data_to_TB, 0);
  endtask

  initial begin
    logic [7:0] d, ed;
    logic       e, pe, oh, fl;

    vecs[0] = '{8'h2E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2E, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};

    rst = 1'b0; rx = 1'b1; read = 1'b0;
    k = 19'd108; eight = 1'b0; p_en = 1'b0; ohel = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", dbg_state, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_read) pulse_read();
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_ovf});
      send_frame(vecs[i].din, vecs[i].eight, vecs[i].p_en, vecs[i].ohel,
                 vecs[i].flip, vecs[i].stop);
      pop_check($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      e  = 1'($urandom_range(0, 1));
      pe = 1'($urandom_range(0, 1));
      oh = 1'($urandom_range(0, 1));
      fl = 1'($urandom_range(0, 1));
      ed = e ? d : {1'b0, d[6:0]};
      pulse_read();
      exp_q.push_back({ed, pe & fl, 1'b0, 1'b0});
      send_frame(d, e, pe, oh, fl, 1'b1);
      pop_check($sformatf("rnd%0d", i));
    end

    // Glitch shorter than half a bit must be rejected as a false start.
    pulse_read();
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 2 * (int'(k) + 1));
    check("glitch_rx_rdy", rx_rdy, 0);
    check("glitch_state", dbg_state, 0);

    // Reset mid-frame, then a clean frame.
    exp_q.push_back({8'h96, 1'b0, 1'b0, 1'b0});
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("pre_rst");
    drive_bit(1'b0, int'(k) + 1);
    drive_bit(1'b1, int'(k) + 1);
    drive_bit(1'b0, 10);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2 * (int'(k) + 1)) @(negedge clk);
    exp_q.push_back({8'hC3, 1'b0, 1'b0, 1'b0});
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pop_check("post_rst");

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
